// File: rtl/serv_rf_pkg.sv
// Shared types and constants for the register-file access sequencer.
package serv_rf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_CSR    = 2'd1,
        MODE_TRAP   = 2'd2,
        MODE_MRET   = 2'd3
    } mode_t;

    localparam int unsigned CSR_BASE  = 32;
    localparam int unsigned MSCRATCH  = 0;
    localparam int unsigned MTVEC     = 1;
    localparam int unsigned MEPC      = 2;
    localparam int unsigned MTVAL     = 3;
    localparam int unsigned GPR_AW    = 5;
    localparam int unsigned CSR_IDX_W = 3;

    // Sequence context latched when a request is accepted.
    typedef struct packed {
        mode_t                mode;
        logic                 rd_wen;
        logic [GPR_AW-1:0]    rd;
        logic [GPR_AW-1:0]    rs1;
        logic [GPR_AW-1:0]    rs2;
        logic [CSR_IDX_W-1:0] csr_idx;
    } ctx_t;

    function automatic logic [5:0] csr_reg(input logic [CSR_IDX_W-1:0] idx);
        return 6'(CSR_BASE) | 6'(idx);
    endfunction

endpackage

// File: rtl/serv_rf_beat_cnt.sv
// Beat counter: advances on non-stalled beats while enabled, flags the final beat.
module serv_rf_beat_cnt #(
    parameter  int unsigned W     = 1,
    localparam int unsigned BEATS = 32 / W,
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          stall,
    output logic [CW-1:0] cnt,
    output logic          last
);

    // BEATS is a power of two, so the increment past the last beat wraps to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (!stall) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = en && (cnt == CW'(BEATS - 1));

endmodule

// File: rtl/serv_rf_seq.sv
// Register-file access sequencer: streams one 32-bit access over BEATS beats of W bits.
module serv_rf_seq
    import serv_rf_pkg::*;
#(
    parameter  int unsigned W        = 1,
    parameter  int unsigned CSR_REGS = 4,
    localparam int unsigned AW       = (CSR_REGS == 0) ? 5 : 6,
    localparam int unsigned CAW      = (CSR_REGS > 1) ? $clog2(CSR_REGS) : 1,
    localparam int unsigned BEATS    = 32 / W,
    localparam int unsigned CW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_req,
    input  logic           i_stall,
    output logic           o_busy,
    output logic           o_done,
    output logic [CW-1:0]  o_cnt,
    output logic           o_last,
    input  logic           i_trap,
    input  logic           i_mret,
    input  logic           i_csr_en,
    input  logic [CAW-1:0] i_csr_addr,
    input  logic           i_rd_wen,
    input  logic [4:0]     i_rd_waddr,
    input  logic [4:0]     i_rs1_raddr,
    input  logic [4:0]     i_rs2_raddr,
    input  logic [W-1:0]   i_alu_rd,
    input  logic [W-1:0]   i_csr_rd,
    input  logic [W-1:0]   i_mem_rd,
    input  logic [W-1:0]   i_ctrl_rd,
    input  logic [W-1:0]   i_csr,
    input  logic [W-1:0]   i_mepc,
    input  logic [W-1:0]   i_mtval,
    input  logic           i_rd_alu_en,
    input  logic           i_rd_csr_en,
    input  logic           i_rd_mem_en,
    output logic [AW-1:0]  o_wreg0,
    output logic [AW-1:0]  o_wreg1,
    output logic [AW-1:0]  o_rreg0,
    output logic [AW-1:0]  o_rreg1,
    output logic           o_wen0,
    output logic           o_wen1,
    output logic [W-1:0]   o_wdata0,
    output logic [W-1:0]   o_wdata1,
    input  logic [W-1:0]   i_rdata0,
    input  logic [W-1:0]   i_rdata1,
    output logic [W-1:0]   o_rs1,
    output logic [W-1:0]   o_rs2,
    output logic [W-1:0]   o_csr
);

    state_t        state;
    state_t        state_nxt;
    ctx_t          ctx;
    ctx_t          ctx_in;
    mode_t         mode_in;
    logic          run;
    logic          wr;
    logic          capture;
    logic [W-1:0]  rd_data;

    assign run     = (state == ST_RUN);
    assign wr      = run && !i_stall;
    assign capture = (state == ST_IDLE) && i_req;

    serv_rf_beat_cnt #(.W(W)) u_beat_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (run),
        .stall (i_stall),
        .cnt   (o_cnt),
        .last  (o_last)
    );

    // Mode priority is resolved once, at acceptance; without CSRs only normal exists.
    always_comb begin
        mode_in = MODE_NORMAL;
        if (CSR_REGS != 0) begin
            if (i_trap)        mode_in = MODE_TRAP;
            else if (i_mret)   mode_in = MODE_MRET;
            else if (i_csr_en) mode_in = MODE_CSR;
        end
        ctx_in.mode    = mode_in;
        ctx_in.rd_wen  = i_rd_wen;
        ctx_in.rd      = i_rd_waddr;
        ctx_in.rs1     = i_rs1_raddr;
        ctx_in.rs2     = i_rs2_raddr;
        ctx_in.csr_idx = CSR_IDX_W'(i_csr_addr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            ctx   <= '0;
        end else begin
            state <= state_nxt;
            if (capture) ctx <= ctx_in;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_req) state_nxt = ST_RUN;
            ST_RUN:  if (o_last && !i_stall) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign rd_data = ({W{i_rd_alu_en}} & i_alu_rd) |
                     ({W{i_rd_csr_en}} & i_csr_rd) |
                     ({W{i_rd_mem_en}} & i_mem_rd) |
                     i_ctrl_rd;

    // Port routing by captured mode; everything is quiet outside RUN.
    always_comb begin
        o_busy   = (state != ST_IDLE);
        o_done   = (state == ST_DONE);
        o_wreg0  = '0;
        o_wreg1  = '0;
        o_rreg0  = '0;
        o_rreg1  = '0;
        o_wen0   = 1'b0;
        o_wen1   = 1'b0;
        o_wdata0 = '0;
        o_wdata1 = '0;
        o_rs1    = '0;
        o_rs2    = '0;
        o_csr    = '0;
        if (run) begin
            o_rreg0 = AW'(ctx.rs1);
            o_rs1   = i_rdata0;
            o_rs2   = i_rdata1;
            case (ctx.mode)
                MODE_NORMAL: begin
                    o_wreg0  = AW'(ctx.rd);
                    o_wdata0 = rd_data;
                    o_wen0   = wr && ctx.rd_wen && (ctx.rd != 5'd0);
                    o_rreg1  = AW'(ctx.rs2);
                end
                MODE_CSR: begin
                    o_wreg0  = AW'(ctx.rd);
                    o_wdata0 = rd_data;
                    o_wen0   = wr && ctx.rd_wen && (ctx.rd != 5'd0);
                    o_wreg1  = AW'(csr_reg(ctx.csr_idx));
                    o_wdata1 = i_csr;
                    o_wen1   = wr;
                    o_rreg1  = AW'(csr_reg(ctx.csr_idx));
                    o_csr    = i_rdata1;
                end
                MODE_TRAP: begin
                    o_wreg0  = AW'(csr_reg(CSR_IDX_W'(MTVAL)));
                    o_wdata0 = i_mtval;
                    o_wen0   = wr;
                    o_wreg1  = AW'(csr_reg(CSR_IDX_W'(MEPC)));
                    o_wdata1 = i_mepc;
                    o_wen1   = wr;
                    o_rreg1  = AW'(csr_reg(CSR_IDX_W'(MTVEC)));
                end
                MODE_MRET: begin
                    o_rreg1  = AW'(csr_reg(CSR_IDX_W'(MEPC)));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serv_rf_seq.sv
// Randomized bench for serv_rf_seq across three W/CSR_REGS configurations against a mode-rule model.
module tb_serv_rf_seq;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       last;
        logic       wen0;
        logic       wen1;
        logic [4:0] cnt;
        logic [5:0] wreg0;
        logic [5:0] wreg1;
        logic [5:0] rreg0;
        logic [5:0] rreg1;
        logic [7:0] wdata0;
        logic [7:0] wdata1;
        logic [7:0] rs1;
        logic [7:0] rs2;
        logic [7:0] csr;
    } obs_t;

    typedef struct {
        int         mode;
        logic       rd_wen;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        int         csr_idx;
    } mctx_t;

    localparam int M_NORMAL = 0;
    localparam int M_CSR    = 1;
    localparam int M_TRAP   = 2;
    localparam int M_MRET   = 3;

    int cfg_w   [3] = '{1, 2, 4};
    int cfg_csr [3] = '{4, 8, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       stall, trap, mret, csr_en, rd_wen;
    logic       rd_alu_en, rd_csr_en, rd_mem_en;
    logic [4:0] rd_waddr, rs1_raddr, rs2_raddr;
    logic [2:0] csr_addr;
    logic [7:0] alu_rd, csr_rd, mem_rd, ctrl_rd, csr_wd, mepc, mtval, rdata0, rdata1;
    obs_t       obs [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WG   = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int unsigned CG   = (g == 0) ? 4 : (g == 1) ? 8 : 0;
        localparam int unsigned AWG  = (CG == 0) ? 5 : 6;
        localparam int unsigned CAWG = (CG == 8) ? 3 : (CG == 4) ? 2 : 1;
        localparam int unsigned CWG  = $clog2(32 / WG);

        logic            busy, done, last, wen0, wen1;
        logic [CWG-1:0]  cnt;
        logic [AWG-1:0]  wreg0, wreg1, rreg0, rreg1;
        logic [WG-1:0]   wdata0, wdata1, rs1, rs2, csr;

        serv_rf_seq #(.W(WG), .CSR_REGS(CG)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_req       (req[g]),
            .i_stall     (stall),
            .o_busy      (busy),
            .o_done      (done),
            .o_cnt       (cnt),
            .o_last      (last),
            .i_trap      (trap),
            .i_mret      (mret),
            .i_csr_en    (csr_en),
            .i_csr_addr  (csr_addr[CAWG-1:0]),
            .i_rd_wen    (rd_wen),
            .i_rd_waddr  (rd_waddr),
            .i_rs1_raddr (rs1_raddr),
            .i_rs2_raddr (rs2_raddr),
            .i_alu_rd    (alu_rd[WG-1:0]),
            .i_csr_rd    (csr_rd[WG-1:0]),
            .i_mem_rd    (mem_rd[WG-1:0]),
            .i_ctrl_rd   (ctrl_rd[WG-1:0]),
            .i_csr       (csr_wd[WG-1:0]),
            .i_mepc      (mepc[WG-1:0]),
            .i_mtval     (mtval[WG-1:0]),
            .i_rd_alu_en (rd_alu_en),
            .i_rd_csr_en (rd_csr_en),
            .i_rd_mem_en (rd_mem_en),
            .o_wreg0     (wreg0),
            .o_wreg1     (wreg1),
            .o_rreg0     (rreg0),
            .o_rreg1     (rreg1),
            .o_wen0      (wen0),
            .o_wen1      (wen1),
            .o_wdata0    (wdata0),
            .o_wdata1    (wdata1),
            .i_rdata0    (rdata0[WG-1:0]),
            .i_rdata1    (rdata1[WG-1:0]),
            .o_rs1       (rs1),
            .o_rs2       (rs2),
            .o_csr       (csr)
        );

        assign obs[g] = '{busy: busy, done: done, last: last, wen0: wen0, wen1: wen1,
                          cnt: 5'(cnt), wreg0: 6'(wreg0), wreg1: 6'(wreg1),
                          rreg0: 6'(rreg0), rreg1: 6'(rreg1),
                          wdata0: 8'(wdata0), wdata1: 8'(wdata1),
                          rs1: 8'(rs1), rs2: 8'(rs2), csr: 8'(csr)};
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_obs(input string tag, input int sel, input obs_t e);
        obs_t o;
        o = obs[sel];
        check($sformatf("%s[%0d]/ctrl", tag, sel),
              128'({o.busy, o.done, o.last, o.wen0, o.wen1, o.cnt}),
              128'({e.busy, e.done, e.last, e.wen0, e.wen1, e.cnt}));
        check($sformatf("%s[%0d]/addr", tag, sel),
              128'({o.wreg0, o.wreg1, o.rreg0, o.rreg1}),
              128'({e.wreg0, e.wreg1, e.rreg0, e.rreg1}));
        check($sformatf("%s[%0d]/data", tag, sel),
              128'({o.wdata0, o.wdata1, o.rs1, o.rs2, o.csr}),
              128'({e.wdata0, e.wdata1, e.rs1, e.rs2, e.csr}));
    endtask

    function automatic mctx_t capture(input int sel);
        mctx_t c;
        c.mode = M_NORMAL;
        if (cfg_csr[sel] != 0) begin
            if (trap)        c.mode = M_TRAP;
            else if (mret)   c.mode = M_MRET;
            else if (csr_en) c.mode = M_CSR;
        end
        c.rd_wen  = rd_wen;
        c.rd      = rd_waddr;
        c.rs1     = rs1_raddr;
        c.rs2     = rs2_raddr;
        c.csr_idx = (cfg_csr[sel] == 0) ? 0 : int'(csr_addr) % cfg_csr[sel];
        return c;
    endfunction

    // Expected outputs from the mode rules; phase 0 = idle, 1 = run, 2 = done.
    function automatic obs_t expect_obs(input int sel, input mctx_t c, input int phase, input int beat);
        obs_t       e;
        int         beats;
        logic [7:0] m;
        logic [7:0] rdd;
        e      = '0;
        beats  = 32 / cfg_w[sel];
        m      = 8'((1 << cfg_w[sel]) - 1);
        e.busy = (phase != 0);
        e.done = (phase == 2);
        if (phase == 1) begin
            rdd     = ((rd_alu_en ? alu_rd : 8'd0) | (rd_csr_en ? csr_rd : 8'd0) |
                       (rd_mem_en ? mem_rd : 8'd0) | ctrl_rd) & m;
            e.cnt   = 5'(beat);
            e.last  = (beat == beats - 1);
            e.rreg0 = {1'b0, c.rs1};
            e.rs1   = rdata0 & m;
            e.rs2   = rdata1 & m;
            case (c.mode)
                M_NORMAL, M_CSR: begin
                    e.wreg0  = {1'b0, c.rd};
                    e.wdata0 = rdd;
                    e.wen0   = !stall && c.rd_wen && (c.rd != 0);
                    e.rreg1  = {1'b0, c.rs2};
                    if (c.mode == M_CSR) begin
                        e.wreg1  = 6'(32 + c.csr_idx);
                        e.wdata1 = csr_wd & m;
                        e.wen1   = !stall;
                        e.rreg1  = 6'(32 + c.csr_idx);
                        e.csr    = rdata1 & m;
                    end
                end
                M_TRAP: begin
                    e.wreg0  = 6'd35;
                    e.wdata0 = mtval & m;
                    e.wen0   = !stall;
                    e.wreg1  = 6'd34;
                    e.wdata1 = mepc & m;
                    e.wen1   = !stall;
                    e.rreg1  = 6'd33;
                end
                default: e.rreg1 = 6'd34;
            endcase
        end
        return e;
    endfunction

    task automatic rand_data();
        alu_rd  = 8'($urandom); csr_rd = 8'($urandom); mem_rd = 8'($urandom);
        ctrl_rd = 8'($urandom); csr_wd = 8'($urandom); mepc   = 8'($urandom);
        mtval   = 8'($urandom); rdata0 = 8'($urandom); rdata1 = 8'($urandom);
    endtask

    task automatic rand_mode_addr();
        trap      = ($urandom_range(0, 3) == 0);
        mret      = ($urandom_range(0, 3) == 0);
        csr_en    = ($urandom_range(0, 1) == 0);
        rd_waddr  = 5'($urandom);
        rs1_raddr = 5'($urandom);
        rs2_raddr = 5'($urandom);
        csr_addr  = 3'($urandom);
    endtask

    task automatic set_ctl(input logic t, input logic mr, input logic ce, input logic we,
                           input logic [4:0] rd, input logic [2:0] ca, input logic ae);
        trap = t; mret = mr; csr_en = ce; rd_wen = we; rd_waddr = rd; csr_addr = ca;
        rs1_raddr = 5'($urandom); rs2_raddr = 5'($urandom);
        rd_alu_en = ae; rd_csr_en = 1'b0; rd_mem_en = 1'b0;
    endtask

    // One request on instance sel; stall_kind 0 none, 1 random, 2 three cycles at beat 3.
    task automatic run_seq(input int sel, input bit rand_cap, input int stall_kind, input int abort_beat);
        mctx_t c;
        int    beats;
        int    beat   = 0;
        int    cyc    = 0;
        int    stalls = 0;
        bit    fin    = 0;
        beats = 32 / cfg_w[sel];
        @(negedge clk);
        req      = '0;
        req[sel] = 1'b1;
        if (rand_cap) begin
            rand_mode_addr();
            rd_wen    = $urandom_range(0, 1) == 1;
            rd_alu_en = $urandom_range(0, 1) == 1;
            rd_csr_en = $urandom_range(0, 1) == 1;
            rd_mem_en = $urandom_range(0, 1) == 1;
        end
        rand_data();
        stall = $urandom_range(0, 1) == 1;
        c = capture(sel);
        #1 check_obs("req", sel, expect_obs(sel, c, 0, 0));
        @(negedge clk);
        while (!fin && cyc < 200) begin
            req[sel] = $urandom_range(0, 1) == 1;
            rand_mode_addr();
            rand_data();
            case (stall_kind)
                1:       stall = ($urandom_range(0, 3) == 0);
                2:       stall = (beat == 3) && (stalls < 3);
                default: stall = 1'b0;
            endcase
            #1 check_obs($sformatf("run_b%0d", beat), sel, expect_obs(sel, c, 1, beat));
            cyc++;
            if (beat == abort_beat) begin
                rst_n = 1'b0;
                #1 check_obs("rst_now", sel, expect_obs(sel, c, 0, 0));
                @(negedge clk);
                req = '0;
                #1 check_obs("rst_hold", sel, expect_obs(sel, c, 0, 0));
                rst_n = 1'b1;
                return;
            end
            if (stall) begin
                stalls++;
            end else begin
                if (beat == beats - 1) fin = 1;
                beat++;
            end
            @(negedge clk);
        end
        check("run_bound", 128'(fin), 128'(1));
        req[sel] = $urandom_range(0, 1) == 1;
        stall    = $urandom_range(0, 1) == 1;
        #1 check_obs("done", sel, expect_obs(sel, c, 2, 0));
        @(negedge clk);
        req = '0;
        #1 check_obs("idle", sel, expect_obs(sel, c, 0, 0));
    endtask

    initial begin
        mctx_t c0;
        rst_n = 1'b0;
        req   = 3'b111;
        stall = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd0, 1'b1);
        rand_data();
        c0 = capture(0);
        #12;
        for (int s = 0; s < 3; s++) check_obs("reset", s, expect_obs(s, c0, 0, 0));
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) check_obs("post_reset", s, expect_obs(s, c0, 0, 0));

        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd0, 1'b1);
        run_seq(0, 1'b0, 0, -1);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 1'b1);
        run_seq(2, 1'b0, 0, -1);
        set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 3'd1, 1'b0);
        run_seq(0, 1'b0, 0, -1);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 3'd0, 1'b1);
        run_seq(1, 1'b0, 2, -1);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 3'd6, 1'b0);
        run_seq(1, 1'b0, 1, -1);
        set_ctl(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 3'd2, 1'b1);
        run_seq(0, 1'b0, 0, -1);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 3'd0, 1'b1);
        run_seq(0, 1'b0, 0, 10);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 3'd3, 1'b1);
        run_seq(0, 1'b0, 0, -1);

        for (int i = 0; i < 36; i++) begin
            run_seq($urandom_range(0, 2), 1'b1, (i % 4 == 0) ? 0 : 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
